wb_write_arbiter: RTL and testbench

Two-master, write-only WISHBONE arbiter that shares one memory write port between the warp destination writer and a second write-only master, such as a frame clear/fill engine. It sits between the masters and the memory controller's write slave. It grants the bus at transfer granularity and enforces a bounded tenure so neither master starves. It also keeps the single-cycle back-to-back ack streaming the pixel writer relies on.

---
 rtl/wb_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Two-master write-only WISHBONE arbiter with bounded tenure and combinational slave mux.
// Build macro WBARB_ROUNDROBIN_EN: ties go to the master that is not `last`; undefined = master 0 wins ties.
module wb_write_arbiter #(
    parameter int unsigned HOLD_MAX = 16  // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       last;

    logic owner_stb;
    logic other_stb;
    logic arb_point;
    logic xfer_done;
    logic forced_release;
    logic tie_pick;

    // Encoding is one-hot on purpose so the grant vector is the state itself.
    assign gnt_o = state;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        owner_stb = 1'b0;
        other_stb = 1'b0;
        case (state)
            GNT0: begin
                owner_stb = m0_stb_i;
                other_stb = m1_stb_i;
            end
            GNT1: begin
                owner_stb = m1_stb_i;
                other_stb = m0_stb_i;
            end
            default: begin
                owner_stb = 1'b0;
                other_stb = 1'b0;
            end
        endcase
    end

    assign arb_point      = (state == IDLE) || !owner_stb;
    assign xfer_done      = owner_stb && s_ack_i;
    assign forced_release = xfer_done && (hold_cnt == HOLD_LAST) && other_stb;

`ifdef WBARB_ROUNDROBIN_EN
    assign tie_pick = ~last;
`else
    assign tie_pick = 1'b0;
`endif

    // Slave side: pure mux of the owner, all-zero while idle.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
            end
            default: begin
                s_adr_o  = '0;
                s_dat_o  = '0;
                s_sel_o  = '0;
                s_stb_o  = 1'b0;
                m0_ack_o = 1'b0;
                m1_ack_o = 1'b0;
            end
        endcase
    end

    // An owner with stb high and no ack is never preempted; only the branches below move state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else if (arb_point) begin
            // NOTE: non-blocking updates so state, hold_cnt and last all see pre-edge values.
            hold_cnt <= '0;
            if (m0_stb_i && m1_stb_i) begin
                state <= tie_pick ? GNT1 : GNT0;
                last  <= tie_pick;
            end else if (m0_stb_i) begin
                state <= GNT0;
                last  <= 1'b0;
            end else if (m1_stb_i) begin
                state <= GNT1;
                last  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end else if (forced_release) begin
            state    <= (state == GNT0) ? GNT1 : GNT0;
            last     <= (state == GNT0);
            hold_cnt <= '0;
        end else if (xfer_done && (hold_cnt != HOLD_LAST)) begin
            // Saturating: a lone owner keeps streaming with the counter parked at HOLD_MAX-1.
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized self-checking bench for wb_write_arbiter against a tenure-level reference model.
// Honors WBARB_ROUNDROBIN_EN the same way the design does.
module tb_wb_write_arbiter;

    localparam int HOLD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0, s_ack_i = 1'b0;
    logic        m0_ack_o, m1_ack_o, s_stb_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;

    wb_write_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: owner index (-1 = idle), transfers completed in this tenure, last winner.
    int own    = -1;
    int tenure = 0;
    int last_w = 1;
    bit done0  = 1'b0;
    bit done1  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int tie_winner();
`ifdef WBARB_ROUNDROBIN_EN
        return 1 - last_w;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string ph);
        logic [1:0]  eg;
        logic        es;
        logic [31:0] ea, ed;
        logic [3:0]  esl;
        logic [1:0]  eack;
        eg = 2'b00; es = 1'b0; ea = '0; ed = '0; esl = '0; eack = 2'b00;
        if (own == 0) begin
            eg = 2'b01; es = m0_stb_i; ea = m0_adr_i; ed = m0_dat_i; esl = m0_sel_i;
            eack = {1'b0, s_ack_i};
        end else if (own == 1) begin
            eg = 2'b10; es = m1_stb_i; ea = m1_adr_i; ed = m1_dat_i; esl = m1_sel_i;
            eack = {s_ack_i, 1'b0};
        end
        check({ph, "/gnt"},  64'(gnt_o), 64'(eg));
        check({ph, "/stb"},  64'(s_stb_o), 64'(es));
        check({ph, "/adr"},  64'(s_adr_o), 64'(ea));
        check({ph, "/dat"},  64'(s_dat_o), 64'(ed));
        check({ph, "/sel"},  64'(s_sel_o), 64'(esl));
        check({ph, "/acks"}, 64'({m1_ack_o, m0_ack_o}), 64'(eack));
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_advance();
        bit req0, req1, mine, theirs;
        int w;
        req0 = m0_stb_i;
        req1 = m1_stb_i;
        mine   = (own == 0) ? req0 : (own == 1) ? req1 : 1'b0;
        theirs = (own == 0) ? req1 : (own == 1) ? req0 : 1'b0;
        if (!mine) begin
            w = -1;
            if (req0 && req1) w = tie_winner();
            else if (req0)    w = 0;
            else if (req1)    w = 1;
            own    = w;
            tenure = 0;
            if (w >= 0) last_w = w;
        end else if (s_ack_i) begin
            tenure++;
            if (tenure >= HOLD_MAX && theirs) begin
                own    = 1 - own;
                last_w = own;
                tenure = 0;
            end
        end
    endtask

    task automatic step(input logic s0, input logic s1, input logic ack,
                        input logic [31:0] a0, input logic [31:0] a1, input string ph);
        @(negedge clk);
        m0_stb_i = s0;
        m1_stb_i = s1;
        s_ack_i  = ack;
        m0_adr_i = a0;
        m1_adr_i = a1;
        m0_dat_i = $urandom;
        m1_dat_i = $urandom;
        m0_sel_i = 4'($urandom);
        m1_sel_i = 4'($urandom);
        #1;
        check_outputs(ph);
        done0 = (own == 0) && s0 && ack;
        done1 = (own == 1) && s1 && ack;
        model_advance();
    endtask

    int         p_tab[6] = '{9, 7, 3, 9, 5, 2};
    logic [1:0] tie_exp;
    logic       r0, r1;

    initial begin
        // Reset state.
        #3;
        check("rst/gnt",  64'(gnt_o), 64'h0);
        check("rst/stb",  64'(s_stb_o), 64'h0);
        check("rst/bus",  64'({s_adr_o, s_sel_o}), 64'h0);
        check("rst/acks", 64'({m1_ack_o, m0_ack_o}), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single master at 0x100 with the slave acking every cycle.
        step(1, 0, 1, 32'h100, $urandom, "t1");
        step(1, 0, 1, 32'h100, $urandom, "t1");
        check("t1/gnt_latency", 64'(gnt_o), 64'h1);
        check("t1/adr",         64'(s_adr_o), 64'h100);
        for (int i = 0; i < 3; i++) step(1, 0, i[0], 32'h100, $urandom, "t1");
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(0, 0, 0, $urandom, $urandom, "drain");

        // Simultaneous requests, both held, slave acking: alternation every HOLD_MAX acks.
        step(1, 1, 1, $urandom, $urandom, "t2");
        step(1, 1, 1, $urandom, $urandom, "t2");
        check("t2/first_gnt", 64'(gnt_o), 64'h1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, $urandom, $urandom, "t2");
        step(1, 1, 1, $urandom, $urandom, "t2");
        check("t2/handover", 64'(gnt_o), 64'h2);
        for (int i = 0; i < 10; i++) step(1, 1, 1, $urandom, $urandom, "t2");
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(0, 0, 0, $urandom, $urandom, "drain");

        // Lone master streams 10 transfers in one tenure past HOLD_MAX.
        step(1, 0, 1, $urandom, $urandom, "t3");
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, $urandom, $urandom, "t3");
            check("t3/stream", 64'({gnt_o, s_stb_o}), 64'h3);
        end
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(0, 0, 0, $urandom, $urandom, "drain");

        // Stalled slave: owner kept through the stall, forced release after 4th completion.
        step(1, 0, 0, $urandom, $urandom, "t4");
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, $urandom, $urandom, "t4");
            check("t4/stall_gnt", 64'(gnt_o), 64'h1);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 1, $urandom, $urandom, "t4");
        step(1, 1, 0, $urandom, $urandom, "t4");
        check("t4/release", 64'(gnt_o), 64'h2);
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(0, 0, 0, $urandom, $urandom, "drain");

        // Tie-break after an m1 tenure, then after an m0 tenure ended by stb drop.
        step(0, 1, 1, $urandom, $urandom, "t5");
        step(0, 1, 1, $urandom, $urandom, "t5");
        step(0, 0, 0, $urandom, $urandom, "t5");
        step(1, 1, 0, $urandom, $urandom, "t5");
        step(1, 1, 1, $urandom, $urandom, "t5");
        check("t5/tie_after_m1", 64'(gnt_o), 64'h1);
        step(0, 0, 0, $urandom, $urandom, "t5");
        step(1, 1, 0, $urandom, $urandom, "t5");
        step(1, 1, 0, $urandom, $urandom, "t5");
`ifdef WBARB_ROUNDROBIN_EN
        tie_exp = 2'b10;
`else
        tie_exp = 2'b01;
`endif
        check("t5/tie_after_m0", 64'(gnt_o), 64'(tie_exp));
        step(1, 1, 1, $urandom, $urandom, "t5");

        // Asynchronous reset while the slave strobe is high.
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(0, 0, 0, $urandom, $urandom, "drain");
        step(1, 0, 1, $urandom, $urandom, "t6");
        step(1, 0, 1, $urandom, $urandom, "t6");
        check("t6/pre_stb", 64'(s_stb_o), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("t6/async_stb",  64'(s_stb_o), 64'h0);
        check("t6/async_gnt",  64'(gnt_o), 64'h0);
        check("t6/async_acks", 64'({m1_ack_o, m0_ack_o}), 64'h0);
        own = -1; tenure = 0; last_w = 1;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 0, $urandom, $urandom, "t6");
        step(0, 1, 1, $urandom, $urandom, "t6");
        check("t6/m1_gnt", 64'(gnt_o), 64'h2);

        // Random traffic; a master holds stb until its transfer is acked.
        r0 = m0_stb_i;
        r1 = m1_stb_i;
        for (int i = 0; i < 3000; i++) begin
            int seg;
            seg = i / 500;
            if (!(r0 && !done0)) r0 = ($urandom_range(0, 9) < p_tab[seg]);
            if (!(r1 && !done1)) r1 = ($urandom_range(0, 9) < p_tab[5 - seg]);
            step(r0, r1, $urandom_range(0, 9) < 6, $urandom, $urandom, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
